inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage of the five-stage pipeline: owns the program counter, drives the combinational instruction ROM's address and chip-enable, and registers the returned word into the IF/ID pipeline register. Selects the next PC from sequential increment, ID-stage branch/jump redirect, the interrupt vector and the exception vector. Generates the EPC write for register $26 so handlers return via `jr $26`. Sits directly upstream of the instruction ROM and feeds the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- IRQ_VECTOR, 32'h0000_0004, interrupt entry address
- EXC_VECTOR, 32'h0000_0008, exception entry address
- clk_i  in  1  single clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  hazard stall from ID; hold PC and IF/ID
- flush_i  in  1  squash IF/ID contents (bubble)
- redirect_i  in  1  taken branch/jump resolved in ID
- redirect_pc_i  in  32  redirect target
- irq_i  in  1  level interrupt request (timer)
- exc_i  in  1  exception raised by instruction in ID
- eret_i  in  1  ID decoded `jr $26`; leave handler mode
- rom_addr_o  out  32  ROM address (= PC register)
- rom_ce_o  out  1  ROM chip enable
- rom_data_i  in  32  ROM instruction word (combinational)
- if_pc_o  out  32  PC of instruction in IF/ID
- if_inst_o  out  32  instruction in IF/ID
- if_valid_o  out  1  IF/ID holds a real instruction
- epc_o  out  32  value to write to $26
- epc_we_o  out  1  one-cycle write strobe for $26

## Operation
- Reset (rst_n_i=0, immediate): PC=RESET_PC, rom_ce_o=0, if_pc_o=0, if_inst_o=0, if_valid_o=0, epc_o=0, epc_we_o=0, in_handler=0.
- Internal flag in_handler: set on IRQ or exception entry, cleared when eret_i=1.
- Next-PC priority, evaluated each edge while rom_ce_o=1:
  1. exc_i: PC<=EXC_VECTOR; epc_o<=if_pc_o+4; IF/ID squashed. Taken even when stall_i=1 or in_handler=1.
  2. redirect_i && !stall_i && redirect_pc_i[1:0]!=0: misaligned, treated as exception: PC<=EXC_VECTOR, epc_o<=redirect_pc_i, IF/ID squashed.
  3. irq_i && !in_handler && !stall_i: PC<=IRQ_VECTOR; epc_o<=redirect_i ? redirect_pc_i : PC; IF/ID squashed (fetched word is refetched after return).
  4. stall_i: PC and IF/ID hold; redirect_i ignored (ID holds it asserted).
  5. redirect_i: PC<=redirect_pc_i; IF/ID loads current word.
  6. Otherwise PC<=PC+4 (mod 2^32, wraps 0xFFFF_FFFC→0); IF/ID loads {PC, rom_data_i}, valid=1.
- flush_i: IF/ID valid<=0 and inst<=0 regardless of stall_i; PC behaviour follows the priority list.
- Squashed IF/ID: if_inst_o=0 (nop), if_valid_o=0, if_pc_o=PC of the discarded fetch.
- epc_we_o=1 for exactly the cycle after entries 1–3; otherwise 0.
- eret_i and irq_i same cycle: in_handler clears this edge; IRQ may be taken next cycle.

## Timing
- rom_ce_o rises on the first rising edge after rst_n_i deasserts; PC holds RESET_PC until then.
- Fetch latency: word at PC appears on if_inst_o one edge after PC presented; first valid IF/ID at second edge after reset release.
- Redirect penalty: one bubble (wrong-path word squashed by flush_i from ID, same cycle as redirect_i).
- Vector entry: vector address on rom_addr_o the cycle after the request; first handler instruction valid in IF/ID one cycle later.
- Reset asserted mid-operation: all state returns to reset values immediately; pending irq/epc discarded.

## Test plan
- Reset release, no stall: rom_addr_o sequence 0x0,0x4,0x8,0xC; if_valid_o rises edge 2 with if_pc_o=0x0, if_inst_o=ROM[0].
- Redirect to 0x40 with flush_i at PC=0x0C: next rom_addr_o=0x40, IF/ID one bubble (valid=0, inst=0), then inst at 0x40.
- stall_i held 3 cycles at PC=0x20 with redirect_i=1: PC and IF/ID frozen; redirect taken on first unstalled edge.
- irq_i=1 at PC=0x18: rom_addr_o=0x4, epc_o=0x18, epc_we_o one cycle; second irq ignored until eret_i, then taken.
- exc_i with if_pc_o=0x4C while stalled: rom_addr_o=0x8, epc_o=0x50, IF/ID squashed.
- Redirect to 0x42: rom_addr_o=0x8, epc_o=0x42, epc_we_o pulses.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM, registers
// the returned word into IF/ID and produces the EPC write for handler entry.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h0000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        irq_i,
  input  logic        exc_i,
  input  logic        eret_i,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  input  logic [31:0] rom_data_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic [31:0] epc_o,
  output logic        epc_we_o
);

  // Architectural state
  logic [31:0] pc_q;
  logic        in_handler_q;

  // Next-state values
  logic [31:0] pc_d, if_pc_d, if_inst_d, epc_d;
  logic        rom_ce_d, if_valid_d, epc_we_d, in_handler_d;

  // Per-cycle decisions
  logic enter;  // vector entry (exception, misaligned redirect or interrupt)
  logic load;   // IF/ID captures the word fetched at pc_q
  logic misaligned;

  assign rom_addr_o = pc_q;
  assign misaligned = redirect_i && !stall_i && (redirect_pc_i[1:0] != 2'b00);

  // Next-PC selection, IF/ID update and handler-entry bookkeeping
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (a missing default in always_comb would infer a latch).
    pc_d         = pc_q;
    if_pc_d      = if_pc_o;
    if_inst_d    = if_inst_o;
    if_valid_d   = if_valid_o;
    epc_d        = epc_o;
    epc_we_d     = 1'b0;
    in_handler_d = in_handler_q;
    rom_ce_d     = 1'b1;
    enter        = 1'b0;
    load         = 1'b0;

    if (rom_ce_o) begin
      if (exc_i) begin
        pc_d  = EXC_VECTOR;
        epc_d = if_pc_o + 32'd4;
        enter = 1'b1;
      end else if (misaligned) begin
        pc_d  = EXC_VECTOR;
        epc_d = redirect_pc_i;
        enter = 1'b1;
      end else if (irq_i && !in_handler_q && !stall_i) begin
        pc_d  = IRQ_VECTOR;
        // A redirect resolved this cycle must be the return point, otherwise
        // the instruction at PC is refetched after the handler.
        epc_d = redirect_i ? redirect_pc_i : pc_q;
        enter = 1'b1;
      end else if (stall_i) begin
        // PC and IF/ID hold; ID keeps any redirect asserted until unstalled.
      end else if (redirect_i) begin
        pc_d = redirect_pc_i;
        load = 1'b1;
      end else begin
        pc_d = pc_q + 32'd4;
        load = 1'b1;
      end

      if (enter) begin
        epc_we_d     = 1'b1;
        if_pc_d      = pc_q;
        if_inst_d    = 32'h0;
        if_valid_d   = 1'b0;
      end else if (load) begin
        if_pc_d      = pc_q;
        if_inst_d    = rom_data_i;
        if_valid_d   = 1'b1;
      end

      // Bubble from ID wins over whatever IF/ID would otherwise capture.
      if (flush_i) begin
        if_inst_d  = 32'h0;
        if_valid_d = 1'b0;
      end

      // Entry sets the flag; eret clears it, so an IRQ arriving with eret is
      // only seen on the following cycle.
      if (enter)       in_handler_d = 1'b1;
      else if (eret_i) in_handler_d = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n_i) begin
      pc_q         <= RESET_PC;
      rom_ce_o     <= 1'b0;
      if_pc_o      <= 32'h0;
      if_inst_o    <= 32'h0;
      if_valid_o   <= 1'b0;
      epc_o        <= 32'h0;
      epc_we_o     <= 1'b0;
      in_handler_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      rom_ce_o     <= rom_ce_d;
      if_pc_o      <= if_pc_d;
      if_inst_o    <= if_inst_d;
      if_valid_o   <= if_valid_d;
      epc_o        <= epc_d;
      epc_we_o     <= epc_we_d;
      in_handler_q <= in_handler_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: ROM returns 0xC0DE_xxxx where xxxx is the
// low half of the address, so every expected word is written out by hand.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redirect, irq, exc, eret;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr, rom_data, if_pc, if_inst, epc;
  logic        rom_ce, if_valid, epc_we;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rom_data = {16'hC0DE, rom_addr[15:0]};

  inst_fetch dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .stall_i       (stall),
    .flush_i       (flush),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .irq_i         (irq),
    .exc_i         (exc),
    .eret_i        (eret),
    .rom_addr_o    (rom_addr),
    .rom_ce_o      (rom_ce),
    .rom_data_i    (rom_data),
    .if_pc_o       (if_pc),
    .if_inst_o     (if_inst),
    .if_valid_o    (if_valid),
    .epc_o         (epc),
    .epc_we_o      (epc_we)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] inst, input logic valid);
    check({tag, ".if_pc"}, if_pc, pc);
    check({tag, ".if_inst"}, if_inst, inst);
    check({tag, ".if_valid"}, {31'h0, if_valid}, {31'h0, valid});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    irq = 1'b0; exc = 1'b0; eret = 1'b0; redirect_pc = 32'h0;

    step();
    check("rst.rom_ce", {31'h0, rom_ce}, 32'h0);
    check("rst.rom_addr", rom_addr, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst.epc_we", {31'h0, epc_we}, 32'h0);
    check("rst.epc", epc, 32'h0);

    rst_n = 1'b1;
    step();
    check("e1.rom_ce", {31'h0, rom_ce}, 32'h1);
    check("e1.rom_addr", rom_addr, 32'h0);
    check("e1.if_valid", {31'h0, if_valid}, 32'h0);
    step();
    check("e2.rom_addr", rom_addr, 32'h4);
    check_ifid("e2", 32'h0, 32'hC0DE_0000, 1'b1);
    step();
    check("e3.rom_addr", rom_addr, 32'h8);
    step();
    check("e4.rom_addr", rom_addr, 32'hC);
    check_ifid("e4", 32'h8, 32'hC0DE_0008, 1'b1);

    // Redirect to 0x40 with flush at PC=0x0C
    redirect = 1'b1; redirect_pc = 32'h40; flush = 1'b1;
    step();
    redirect = 1'b0; flush = 1'b0;
    check("rd.rom_addr", rom_addr, 32'h40);
    check_ifid("rd.bubble", 32'hC, 32'h0, 1'b0);
    step();
    check("rd2.rom_addr", rom_addr, 32'h44);
    check_ifid("rd2", 32'h40, 32'hC0DE_0040, 1'b1);

    // Reach PC=0x20 with 0x1C in IF/ID, then stall with a pending redirect
    redirect = 1'b1; redirect_pc = 32'h1C; flush = 1'b1;
    step();
    redirect = 1'b0; flush = 1'b0;
    step();
    check("pre_st.rom_addr", rom_addr, 32'h20);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("st%0d.rom_addr", i), rom_addr, 32'h20);
      check_ifid($sformatf("st%0d", i), 32'h1C, 32'hC0DE_001C, 1'b1);
    end
    stall = 1'b0; flush = 1'b1;
    step();
    redirect = 1'b0; flush = 1'b0;
    check("st_rel.rom_addr", rom_addr, 32'h80);
    check("st_rel.if_valid", {31'h0, if_valid}, 32'h0);
    step();
    check("st_rel2.rom_addr", rom_addr, 32'h84);
    check_ifid("st_rel2", 32'h80, 32'hC0DE_0080, 1'b1);

    // Interrupt at PC=0x18
    redirect = 1'b1; redirect_pc = 32'h18; flush = 1'b1;
    step();
    redirect = 1'b0; flush = 1'b0;
    irq = 1'b1;
    step();
    check("irq.rom_addr", rom_addr, 32'h4);
    check("irq.epc", epc, 32'h18);
    check("irq.epc_we", {31'h0, epc_we}, 32'h1);
    check_ifid("irq.squash", 32'h18, 32'h0, 1'b0);
    step();
    check("irq_hnd.rom_addr", rom_addr, 32'h8);
    check("irq_hnd.epc_we", {31'h0, epc_we}, 32'h0);
    check_ifid("irq_hnd", 32'h4, 32'hC0DE_0004, 1'b1);
    step();
    check("irq_ign.rom_addr", rom_addr, 32'hC);
    // eret (jr $26) with irq still high: return taken, irq waits one cycle
    eret = 1'b1; redirect = 1'b1; redirect_pc = 32'h18; flush = 1'b1;
    step();
    eret = 1'b0; redirect = 1'b0; flush = 1'b0;
    check("eret.rom_addr", rom_addr, 32'h18);
    check("eret.epc_we", {31'h0, epc_we}, 32'h0);
    step();
    irq = 1'b0;
    check("irq2.rom_addr", rom_addr, 32'h4);
    check("irq2.epc", epc, 32'h18);
    check("irq2.epc_we", {31'h0, epc_we}, 32'h1);

    // Exception while stalled with 0x4C in IF/ID
    redirect = 1'b1; redirect_pc = 32'h4C; flush = 1'b1;
    step();
    redirect = 1'b0; flush = 1'b0;
    step();
    check_ifid("pre_exc", 32'h4C, 32'hC0DE_004C, 1'b1);
    stall = 1'b1; exc = 1'b1;
    step();
    stall = 1'b0; exc = 1'b0;
    check("exc.rom_addr", rom_addr, 32'h8);
    check("exc.epc", epc, 32'h50);
    check("exc.epc_we", {31'h0, epc_we}, 32'h1);
    check_ifid("exc.squash", 32'h50, 32'h0, 1'b0);
    step();
    check("post_exc.rom_addr", rom_addr, 32'hC);
    check("post_exc.epc_we", {31'h0, epc_we}, 32'h0);

    // Misaligned redirect to 0x42
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    check("mis.rom_addr", rom_addr, 32'h8);
    check("mis.epc", epc, 32'h42);
    check("mis.epc_we", {31'h0, epc_we}, 32'h1);
    check("mis.if_valid", {31'h0, if_valid}, 32'h0);
    step();
    check("mis2.epc_we", {31'h0, epc_we}, 32'h0);
    check("mis2.rom_addr", rom_addr, 32'hC);

    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; flush = 1'b1;
    step();
    redirect = 1'b0; flush = 1'b0;
    check("wrap0.rom_addr", rom_addr, 32'hFFFF_FFFC);
    step();
    check("wrap1.rom_addr", rom_addr, 32'h0);
    check_ifid("wrap1", 32'hFFFF_FFFC, 32'hC0DE_FFFC, 1'b1);

    // Asynchronous reset mid-operation takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("arst.rom_ce", {31'h0, rom_ce}, 32'h0);
    check("arst.rom_addr", rom_addr, 32'h0);
    check("arst.epc", epc, 32'h0);
    check_ifid("arst", 32'h0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  // Guard against a run that never reaches the summary
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
